// File: rtl/calc_pkg.sv
// Shared constants and types for the calculation result serializer.
// Result count, index width, index names and the FSM state encoding.
package calc_pkg;

  localparam int BW_DEF = 8;
  localparam int NRES   = 6;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] IDX_S1 = 3'd0;
  localparam logic [IDX_W-1:0] IDX_S2 = 3'd1;
  localparam logic [IDX_W-1:0] IDX_S3 = 3'd2;
  localparam logic [IDX_W-1:0] IDX_S4 = 3'd3;
  localparam logic [IDX_W-1:0] IDX_S5 = 3'd4;
  localparam logic [IDX_W-1:0] IDX_S6 = 3'd5;

  localparam logic [IDX_W-1:0] DIV0_IDX = IDX_S3;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

endpackage

// File: rtl/calc_result_serializer.sv
// Captures a six-result frame in one transfer and replays it one result per beat.
// Ports: clk, rst_n, in_valid/in_ready/in_s1..6/in_div0, out_valid/out_ready/out_data/out_idx/out_last/out_div0, frame_cnt.
module calc_result_serializer
  import calc_pkg::*;
#(
  parameter int BW = BW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_s1,
  input  logic [BW-1:0]    in_s2,
  input  logic [BW-1:0]    in_s3,
  input  logic [BW-1:0]    in_s4,
  input  logic [BW-1:0]    in_s5,
  input  logic [BW-1:0]    in_s6,
  input  logic             in_div0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_div0,
  output logic [15:0]      frame_cnt
);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nx;
  logic [BW-1:0]    cap [NRES];
  logic             div0_q;
  logic [BW-1:0]    data_sel;

  logic fire;
  logic last_fire;
  logic accept;

  assign out_valid = (state == ST_SEND);
  assign out_idx   = idx;
  assign out_last  = out_valid & (idx == IDX_S6);
  assign out_div0  = out_valid & div0_q
                   & (idx == DIV0_IDX);

  assign fire      = out_valid & out_ready;
  assign last_fire = fire & out_last;

  // A new frame may load in the same cycle the
  // last beat leaves, keeping the stream gapless.
  assign in_ready  = rst_n
                   & ((state == ST_IDLE) | last_fire);
  assign accept    = in_valid & in_ready;

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NRES; i++) begin
      if (idx == IDX_W'(i)) data_sel = cap[i];
    end
  end

  assign out_data = out_valid ? data_sel : '0;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_SEND;
          idx_nx   = IDX_S1;
        end
      end
      ST_SEND: begin
        if (fire) begin
          if (out_last) begin
            idx_nx   = IDX_S1;
            state_nx = accept ? ST_SEND : ST_IDLE;
          end else begin
            idx_nx   = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = IDX_S1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= IDX_S1;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRES; i++) cap[i] <= '0;
      div0_q <= 1'b0;
    end else if (accept) begin
      cap[0] <= in_s1;
      cap[1] <= in_s2;
      cap[2] <= in_s3;
      cap[3] <= in_s4;
      cap[4] <= in_s5;
      cap[5] <= in_s6;
      div0_q <= in_div0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (last_fire) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_calc_result_serializer.sv
// Bench for calc_result_serializer: directed table frames, corner sequences,
// and randomized traffic against a beat-queue reference model.
module tb_calc_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  s [6];
  logic        in_div0 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_div0;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] cnt_exp = '0;

  always #5 clk = ~clk;

  calc_result_serializer #(.BW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s1(s[0]), .in_s2(s[1]), .in_s3(s[2]),
    .in_s4(s[3]), .in_s5(s[4]), .in_s6(s[5]),
    .in_div0(in_div0),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_div0(out_div0),
    .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [5:0][7:0] s;
    logic            div0;
    logic [5:0][7:0] ed;
    logic [5:0]      ediv;
    logic [5:0]      elast;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
    logic       div0;
    logic       last;
  } beat_t;

  vec_t  tv [3];
  beat_t q [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_idx > 3'd5) begin
      errors++;
      $display("FAIL idx_range: got %0d want <=5",
               out_idx);
    end
  end

  task automatic load(input vec_t v);
    for (int i = 0; i < 6; i++) s[i] = v.s[i];
    in_div0 = v.div0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  // Present a frame, then check its six beats at full rate.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    out_ready = 1'b1;
    load(v);
    in_valid = 1'b1;
    #1;
    wait_ready();
    chk("vec_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      #1;
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, v.ed[b]);
      chk("vec_idx", out_idx, b);
      chk("vec_last", out_last, v.elast[b]);
      chk("vec_div0", out_div0, v.ediv[b]);
      chk("vec_in_ready", in_ready, b == 5);
      @(negedge clk);
    end
    cnt_exp = cnt_exp + 16'd1;
    #1;
    chk("vec_done_valid", out_valid, 0);
    chk("vec_frame_cnt", frame_cnt, cnt_exp);
  endtask

  initial begin
    tv[0].s     = {8'h2C, 8'h04, 8'h3B,
                   8'h05, 8'h15, 8'h0A};
    tv[0].div0  = 1'b0;
    tv[0].ed    = {8'h2C, 8'h04, 8'h3B,
                   8'h05, 8'h15, 8'h0A};
    tv[0].ediv  = 6'b000000;
    tv[0].elast = 6'b100000;

    tv[1].s     = {8'h66, 8'h55, 8'h44,
                   8'hFF, 8'h22, 8'h11};
    tv[1].div0  = 1'b1;
    tv[1].ed    = {8'h66, 8'h55, 8'h44,
                   8'hFF, 8'h22, 8'h11};
    tv[1].ediv  = 6'b000100;
    tv[1].elast = 6'b100000;

    tv[2].s     = {8'hFE, 8'h01, 8'h7F,
                   8'h80, 8'hFF, 8'h00};
    tv[2].div0  = 1'b0;
    tv[2].ed    = {8'hFE, 8'h01, 8'h7F,
                   8'h80, 8'hFF, 8'h00};
    tv[2].ediv  = 6'b000000;
    tv[2].elast = 6'b100000;

    for (int i = 0; i < 6; i++) s[i] = '0;

    // Reset state
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_div0", out_div0, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 3; i++) run_vec(tv[i]);

    // Backpressure: ready 1,0,0,1 repeating
    begin
      logic [3:0] pat;
      int b;
      int k;
      pat = 4'b1001;
      b = 0;
      k = 0;
      @(negedge clk);
      load(tv[0]);
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      while (b < 6 && k < 40) begin
        out_ready = pat[k % 4];
        #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, tv[0].ed[b]);
        chk("bp_idx", out_idx, b);
        chk("bp_last", out_last, b == 5);
        chk("bp_in_ready", in_ready,
            out_ready && b == 5);
        if (out_ready) b++;
        k++;
        @(negedge clk);
      end
      chk("bp_beats", b, 6);
      cnt_exp = cnt_exp + 16'd1;
      #1;
      chk("bp_cnt", frame_cnt, cnt_exp);
    end

    // Back-to-back frames: 12 beats in 12 cycles
    @(negedge clk);
    out_ready = 1'b1;
    load(tv[0]);
    in_valid = 1'b1;
    @(negedge clk);
    load(tv[2]);
    for (int k = 0; k < 12; k++) begin
      if (k == 6) in_valid = 1'b0;
      #1;
      chk("b2b_valid", out_valid, 1);
      chk("b2b_idx", out_idx, k % 6);
      chk("b2b_data", out_data,
          k < 6 ? tv[0].ed[k] : tv[2].ed[k-6]);
      chk("b2b_in_ready", in_ready, k % 6 == 5);
      @(negedge clk);
    end
    cnt_exp = cnt_exp + 16'd2;
    #1;
    chk("b2b_end_valid", out_valid, 0);
    chk("b2b_cnt", frame_cnt, cnt_exp);

    // Reset during idx3 beat
    @(negedge clk);
    load(tv[1]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_idx3", out_idx, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_ready", in_ready, 0);
    cnt_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("post_rst_idle", out_valid, 0);
    end
    run_vec(tv[2]);

    // frame_cnt wrap
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    cnt_exp = 16'hFFFF;
    run_vec(tv[0]);

    // Randomized traffic against beat-queue model
    begin
      logic pend;
      logic exp_rdy;
      logic fire;
      logic acc;
      pend = 1'b0;
      q.delete();
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (!pend) begin
          in_valid = ($urandom_range(0, 1) == 1);
          for (int i = 0; i < 6; i++)
            s[i] = 8'($urandom);
          in_div0 = ($urandom_range(0, 3) == 0);
        end
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        chk("rnd_cnt", frame_cnt, cnt_exp);
        chk("rnd_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
          chk("rnd_data", out_data, q[0].data);
          chk("rnd_idx", out_idx, q[0].idx);
          chk("rnd_last", out_last, q[0].last);
          chk("rnd_div0", out_div0, q[0].div0);
        end
        exp_rdy = (q.size() == 0)
               || (q.size() == 1 && out_ready);
        chk("rnd_in_ready", in_ready, exp_rdy);
        fire = (q.size() != 0) && out_ready;
        if (fire) begin
          if (q[0].last) cnt_exp = cnt_exp + 16'd1;
          void'(q.pop_front());
        end
        acc = in_valid && exp_rdy;
        if (acc) begin
          for (int i = 0; i < 6; i++) begin
            beat_t bt;
            bt.data = s[i];
            bt.idx  = 3'(i);
            bt.div0 = in_div0 && (i == 2);
            bt.last = (i == 5);
            q.push_back(bt);
          end
        end
        pend = in_valid && !acc;
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
